// File: rtl/sad_accum5_pkg.sv
// sad_pkg: shared constants, state encoding and saturating add for the SAD accumulator
package sad_pkg;
  localparam int PIX_W      = 8;
  localparam int SAD_W      = 14;
  localparam int N_CAND     = 5;
  localparam int BLK_PIXELS = 64;
  localparam int CNT_W      = $clog2(BLK_PIXELS + 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [SAD_W:0] s;
    s = {1'b0, a} + {{(SAD_W + 1 - PIX_W){1'b0}}, b};
    return s[SAD_W] ? {SAD_W{1'b1}} : s[SAD_W-1:0];
  endfunction
endpackage

// File: rtl/sad_accum5_abs_diff.sv
// abs_diff: combinational unsigned absolute difference of two pixels
module abs_diff
  import sad_pkg::*;
(
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [PIX_W-1:0] o_d
);
  assign o_d = (i_a > i_b) ? i_a - i_b : i_b - i_a;
endmodule

// File: rtl/sad_accum5.sv
// sad_accum5: accumulates five candidate SADs over one block and presents them packed
module sad_accum5
  import sad_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_start,
  input  logic [PIX_W-1:0]          cur_pix,
  input  logic [N_CAND*PIX_W-1:0]   ref_pix,
  output logic [N_CAND*SAD_W-1:0]   sad_vec,
  output logic                      sad_valid,
  output logic                      busy,
  output logic                      drop_err,
  output logic                      abort_err
);
  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic [SAD_W-1:0]        r_acc [N_CAND];
  logic [PIX_W-1:0]        w_term [N_CAND];
  logic [N_CAND*SAD_W-1:0] w_sum, r_sad_vec;
  logic                    w_take, w_done, r_sad_valid, r_drop, r_abort;

  // in_start always loads, so an aborting beat becomes the first beat of the new block
  for (genvar i = 0; i < N_CAND; i++) begin : g_cand
    abs_diff u_ad (.i_a(cur_pix), .i_b(ref_pix[PIX_W*i +: PIX_W]), .o_d(w_term[i]));
    assign w_sum[SAD_W*i +: SAD_W] = in_start ? {{(SAD_W - PIX_W){1'b0}}, w_term[i]}
                                              : sat_add(r_acc[i], w_term[i]);
  end

  always_comb begin
    w_take = in_valid & (in_start | (r_state == ACCUM));
    w_cnt  = in_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
    w_done = w_take & (w_cnt == CNT_W'(BLK_PIXELS));
    w_next = w_take ? (w_done ? IDLE : ACCUM) : r_state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sad_vec   <= '0;
      r_sad_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_abort     <= 1'b0;
      for (int j = 0; j < N_CAND; j++) r_acc[j] <= '0;
    end else begin
      r_sad_valid <= w_done;
      r_drop      <= in_valid & ~in_start & (r_state == IDLE);
      r_abort     <= in_valid & in_start & (r_state == ACCUM);
      if (w_take) r_cnt <= w_done ? '0 : w_cnt;
      if (w_take)
        for (int j = 0; j < N_CAND; j++) r_acc[j] <= w_done ? '0 : w_sum[SAD_W*j +: SAD_W];
      if (w_done) r_sad_vec <= w_sum;
    end
  end

  assign sad_vec   = r_sad_vec;
  assign sad_valid = r_sad_valid;
  assign busy      = (r_state == ACCUM);
  assign drop_err  = r_drop;
  assign abort_err = r_abort;
endmodule

// File: tb/tb_sad_accum5.sv
// tb_sad_accum5: randomized scoreboard bench for sad_accum5 against a block-level SAD model
module tb_sad_accum5;
  import sad_pkg::*;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_start = 0;
  logic [7:0]  cur_pix = 0;
  logic [39:0] ref_pix = 0;
  logic [69:0] sad_vec;
  logic        sad_valid, busy, drop_err, abort_err;

  sad_accum5 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
                  .cur_pix(cur_pix), .ref_pix(ref_pix), .sad_vec(sad_vec), .sad_valid(sad_valid),
                  .busy(busy), .drop_err(drop_err), .abort_err(abort_err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [69:0] v; int c; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_acc [5];
  int m_cnt = 0;
  bit pend_drop = 0, pend_abort = 0, exp_busy = 0, exp_drop = 0, exp_abort = 0;
  logic [69:0] exp_vec = '0;

  task automatic chk(input string n, input logic [69:0] a, input logic [69:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // block-level reference: a block is 64 accepted beats starting with in_start
  function automatic void model(bit v, bit s, logic [7:0] c, logic [39:0] r);
    exp_t e;
    pend_drop = 0;
    pend_abort = 0;
    if (!v) return;
    if (m_cnt == 0 && !s) begin
      pend_drop = 1;
      return;
    end
    if (s) begin
      pend_abort = (m_cnt != 0);
      m_cnt = 0;
      foreach (m_acc[i]) m_acc[i] = 0;
    end
    foreach (m_acc[i]) begin
      int d;
      d = int'(c) - int'(r[8*i +: 8]);
      m_acc[i] += (d < 0) ? -d : d;
    end
    m_cnt++;
    if (m_cnt == BLK_PIXELS) begin
      e.v = '0;
      foreach (m_acc[i]) e.v[14*i +: 14] = 14'((m_acc[i] > 16383) ? 16383 : m_acc[i]);
      e.c = cyc + 1;
      q.push_back(e);
      m_cnt = 0;
    end
  endfunction

  task automatic step(input bit v, input bit s, input logic [7:0] c, input logic [39:0] r);
    @(posedge clk);
    #1;
    exp_busy  = (m_cnt != 0);
    exp_drop  = pend_drop;
    exp_abort = pend_abort;
    model(v, s, c, r);
    in_valid = v;
    in_start = s;
    cur_pix  = c;
    ref_pix  = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'($urandom), 8'($urandom), {$urandom, 8'($urandom)});
  endtask

  task automatic blk(input int n, input bit fixed, input logic [7:0] c, input logic [39:0] r);
    for (int i = 0; i < n; i++)
      if (fixed) step(1, i == 0, c, r);
      else       step(1, i == 0, 8'($urandom), {$urandom, 8'($urandom)});
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    rst_n = 0;
    in_valid = 0;
    in_start = 0;
    m_cnt = 0;
    pend_drop = 0;
    pend_abort = 0;
    exp_busy = 0;
    exp_drop = 0;
    exp_abort = 0;
    exp_vec = '0;
    q.delete();
    #1;
    chk("rst_vec", sad_vec, '0);
    chk("rst_flags", {sad_valid, busy, drop_err, abort_err}, '0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", busy, exp_busy);
      chk("drop_err", drop_err, exp_drop);
      chk("abort_err", abort_err, exp_abort);
      if (sad_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sad_valid_unexpected: got 1 want 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          exp_vec = e.v;
          chk("sad_latency", 70'(cyc), 70'(e.c));
        end
      end
      chk("sad_vec", sad_vec, exp_vec);
    end
  end

  initial begin
    logic [7:0] c;
    int idx;
    do_reset(2);
    idle(2);
    c = 8'($urandom);
    blk(64, 1, c, {5{c}});
    idle(3);
    blk(64, 1, 8'd255, {8'd0, 8'd255, 8'd128, 8'd255, 8'd0});
    idle(2);
    chk("pattern_fields", sad_vec, {14'd16320, 14'd0, 14'd8128, 14'd0, 14'd16320});
    idx = 0;
    for (int i = 1; i < 5; i++) if (sad_vec[14*i +: 14] < sad_vec[14*idx +: 14]) idx = i;
    chk("argmin", 70'(idx), 70'(1));
    for (int i = 0; i < 64; i++) begin
      step(1, i == 0, 8'($urandom), {$urandom, 8'($urandom)});
      if (i == 9 || i == 39) idle(3);
    end
    idle(2);
    blk(20, 0, 0, 0);
    blk(64, 0, 0, 0);
    idle(2);
    step(1, 0, 8'($urandom), {$urandom, 8'($urandom)});
    idle(3);
    blk(30, 0, 0, 0);
    do_reset(2);
    blk(64, 0, 0, 0);
    idle(2);
    blk(64, 0, 0, 0);
    blk(64, 1, 8'd10, 40'd0);
    idle(2);
    chk("b2b_640", sad_vec, {5{14'd640}});
    for (int b = 0; b < 40; b++) begin
      case ($urandom_range(0, 9))
        0: step(1, 0, 8'($urandom), {$urandom, 8'($urandom)});
        1: blk($urandom_range(1, 63), 0, 0, 0);
        default:
          for (int k = 0; k < 64; k++) begin
            while ($urandom_range(0, 9) == 0) idle(1);
            step(1, k == 0, 8'($urandom), {$urandom, 8'($urandom)});
          end
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_empty", 70'(q.size()), 70'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
